// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry type for the decoupled fetch unit.
package fetch_pkg;

  localparam logic [31:0] PC_START = 32'h0100_0000;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO of fetch entries; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch: credit-limited sequential imem requests, in-order
// instruction queue toward decode, redirect flush with stale-response drop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(PC_START),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              req_valid_o,
  output logic [AWIDTH-1:0] req_addr_o,
  input  logic              req_ready_i,
  input  logic              rsp_valid_i,
  input  logic [DWIDTH-1:0] rsp_data_i,
  output logic              inst_valid_o,
  output logic [DWIDTH-1:0] inst_o,
  output logic [AWIDTH-1:0] inst_pc_o,
  input  logic              inst_ready_i,
  output logic [CW-1:0]     count_o
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] inst;
  } entry_t;

  localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

  logic [AWIDTH-1:0] fetch_pc;
  logic [AWIDTH-1:0] rsp_pc;
  logic [AWIDTH-1:0] redirect_target;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic              req_fire;
  logic              keep;
  logic              pop;
  logic              unused_pc_lsb;
  entry_t            push_entry;
  entry_t            head;

  assign redirect_target = {redirect_pc_i[AWIDTH-1:2], 2'b00};
  assign unused_pc_lsb   = ^redirect_pc_i[1:0];

  // Queue slots and outstanding requests share one credit pool of DEPTH,
  // which is what keeps a kept response from ever overflowing the queue.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign req_valid_o = !rst && !redirect_i && (credit_used < FULL);
  assign req_addr_o  = fetch_pc;
  assign req_fire    = req_valid_o && req_ready_i;

  assign keep         = rsp_valid_i && (drop_cnt == '0) && !redirect_i;
  assign inst_valid_o = !rst && (fifo_count != '0);
  assign pop          = inst_valid_o && inst_ready_i && !redirect_i;
  assign count_o      = rst ? '0 : fifo_count;
  assign push_entry   = '{pc: rsp_pc, inst: rsp_data_i};
  assign inst_o       = head.inst;
  assign inst_pc_o    = head.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(rsp_valid_i);
      if (redirect_i) begin
        // A response landing in the redirect cycle is stale too.
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        drop_cnt <= inflight - CW'(rsp_valid_i);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + AWIDTH'(4);
        if (keep)     rsp_pc   <= rsp_pc + AWIDTH'(4);
        if (rsp_valid_i && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rsp_valid_i && (inflight == '0)));
      assert (credit_used <= FULL);
      assert (drop_cnt <= inflight);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_i),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a small latency-programmable imem model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] RPC = 32'h0100_0000;

  logic          clk;
  logic          rst;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          req_valid_o;
  logic [31:0]   req_addr_o;
  logic          req_ready_i;
  logic          rsp_valid_i;
  logic [31:0]   rsp_data_i;
  logic          inst_valid_o;
  logic [31:0]   inst_o;
  logic [31:0]   inst_pc_o;
  logic          inst_ready_i;
  logic [CW-1:0] count_o;

  fetch_queue #(.AWIDTH(32), .DWIDTH(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .req_valid_o   (req_valid_o),
    .req_addr_o    (req_addr_o),
    .req_ready_i   (req_ready_i),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_data_i    (rsp_data_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i),
    .count_o       (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_in;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t        tbl [5];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] pend_addr [$];
  int          pend_due [$];
  logic [31:0] exp_q [$];
  logic [31:0] req_exp;
  logic [31:0] first_pop;
  int          pops;
  int          first_fire;
  int          first_valid;
  int          gaps;
  bit          track_gaps = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_seq(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
    pops = 0;
    first_pop = '0;
  endtask

  // One clock cycle: imem model drives its response, then handshakes are sampled.
  task automatic step();
    logic [31:0] e;
    rsp_valid_i = 1'b0;
    rsp_data_i  = '0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = inst_of(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
    if (req_valid_o && req_ready_i) begin
      check("req_addr", req_addr_o, req_exp);
      req_exp += 32'd4;
      pend_addr.push_back(req_addr_o);
      pend_due.push_back(cyc + lat);
      if (first_fire < 0) first_fire = cyc;
    end
    if (inst_valid_o) begin
      if (first_valid < 0) first_valid = cyc;
    end else if (track_gaps && first_valid >= 0) begin
      gaps++;
    end
    if (inst_valid_o && inst_ready_i && !redirect_i) begin
      pops++;
      if (pops == 1) first_pop = inst_pc_o;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_extra: got pc %0h expected no pop", inst_pc_o);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", inst_pc_o, e);
        check("pop_inst", inst_o, inst_of(e));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reset with the imem reset alongside it: pending responses vanish.
  task automatic do_reset();
    rst = 1'b1;
    redirect_i = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    #1;
    check("rst_req_valid", 32'(req_valid_o), 32'd0);
    check("rst_inst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    step();
    check("rst_count_next", 32'(count_o), 32'd0);
    step();
    rst = 1'b0;
    req_exp = RPC;
    expect_seq(RPC);
    first_fire = -1;
    first_valid = -1;
    gaps = 0;
    #1;
    check("post_rst_count", 32'(count_o), 32'd0);
    check("post_rst_inst_valid", 32'(inst_valid_o), 32'd0);
    check("post_rst_req_valid", 32'(req_valid_o), 32'(req_ready_i | 1'b1));
    check("post_rst_addr", req_addr_o, RPC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h0100_0102, 32'h0100_0100};
    tbl[1] = '{32'h0000_0003, 32'h0000_0000};
    tbl[2] = '{32'h1234_5678, 32'h1234_5678};
    tbl[3] = '{32'h0100_0101, 32'h0100_0100};
    tbl[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF8};

    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    req_ready_i = 1'b1; inst_ready_i = 1'b1;
    rsp_valid_i = 1'b0; rsp_data_i = '0;
    @(posedge clk);
    #1;

    // Streaming at L=1
    lat = 1;
    do_reset();
    track_gaps = 1;
    repeat (30) step();
    track_gaps = 0;
    check("stream_latency", 32'(first_valid - first_fire), 32'd2);
    check("stream_gaps", 32'(gaps), 32'd0);
    check("stream_pops", 32'(pops), 32'd28);

    // Decode stalled from the start
    inst_ready_i = 1'b0;
    do_reset();
    repeat (10) step();
    check("bp_count_full", 32'(count_o), 32'd4);
    check("bp_req_valid", 32'(req_valid_o), 32'd0);
    check("bp_head_valid", 32'(inst_valid_o), 32'd1);
    check("bp_head_pc", inst_pc_o, RPC);
    check("bp_req_exp", req_exp, 32'h0100_0010);
    inst_ready_i = 1'b1;
    repeat (12) step();
    check("bp_pops", 32'(pops), 32'd12);

    // Redirect with two requests outstanding at L=3
    lat = 3;
    do_reset();
    step();
    step();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0100_0100;
    req_exp = 32'h0100_0100;
    expect_seq(32'h0100_0100);
    #1;
    check("rd2_req_valid_during", 32'(req_valid_o), 32'd0);
    step();
    redirect_i = 1'b0;
    #1;
    check("rd2_count", 32'(count_o), 32'd0);
    check("rd2_req_valid", 32'(req_valid_o), 32'd1);
    check("rd2_addr", req_addr_o, 32'h0100_0100);
    repeat (12) step();
    check("rd2_first_pop", first_pop, 32'h0100_0100);
    check("rd2_some_pops", 32'(pops > 0), 32'd1);

    // Redirect coinciding with a response and a ready decode, count=2
    lat = 1;
    inst_ready_i = 1'b0;
    do_reset();
    repeat (3) step();
    check("rdc_count_before", 32'(count_o), 32'd2);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    inst_ready_i = 1'b1;
    req_exp = 32'h0000_0200;
    expect_seq(32'h0000_0200);
    step();
    check("rdc_pops_in_redirect", 32'(pops), 32'd0);
    redirect_i = 1'b0;
    #1;
    check("rdc_count_after", 32'(count_o), 32'd0);
    check("rdc_inst_valid", 32'(inst_valid_o), 32'd0);
    repeat (8) step();
    check("rdc_first_pop", first_pop, 32'h0000_0200);

    // Back-to-back redirects at L=2: only the second target is fetched
    lat = 2;
    do_reset();
    repeat (6) step();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0100_0200;
    req_exp = 32'h0100_0300;
    expect_seq(32'h0100_0300);
    step();
    redirect_pc_i = 32'h0100_0300;
    step();
    redirect_i = 1'b0;
    repeat (12) step();
    check("b2b_first_pop", first_pop, 32'h0100_0300);
    check("b2b_pops", 32'(pops >= 5), 32'd1);

    // Reset mid-stream with count=3 and one request outstanding
    lat = 1;
    inst_ready_i = 1'b0;
    do_reset();
    repeat (4) step();
    check("mrst_count_before", 32'(count_o), 32'd3);
    do_reset();
    inst_ready_i = 1'b1;
    repeat (8) step();
    check("mrst_first_pop", first_pop, RPC);

    // Table: redirect alignment with no requests accepted
    req_ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      redirect_i = 1'b1;
      redirect_pc_i = tbl[i].pc_in;
      #1;
      check("tbl_req_valid_during", 32'(req_valid_o), 32'd0);
      step();
      redirect_i = 1'b0;
      #1;
      check("tbl_req_valid", 32'(req_valid_o), 32'd1);
      check("tbl_addr", req_addr_o, tbl[i].exp_addr);
      check("tbl_count", 32'(count_o), 32'd0);
    end

    // Fetch across the top of the address space
    req_ready_i = 1'b1;
    req_exp = 32'hFFFF_FFF8;
    expect_seq(32'hFFFF_FFF8);
    repeat (10) step();
    check("wrap_first_pop", first_pop, 32'hFFFF_FFF8);
    check("wrap_pops", 32'(pops >= 4), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-PC fetch stage: a decoupled fetch unit that issues sequential instruction-memory requests over a valid/ready handshake.
- Buffers up to DEPTH returned instructions, each paired with its PC, in an in-order queue feeding decode.
- Handles redirects from execute: a taken branch or jump flushes the queue and discards stale in-flight responses.
- Sits between the instruction memory port and decode, replacing direct PC-to-imem wiring.

Parameters:
- AWIDTH, 32, address/PC width.
- DWIDTH, 32, instruction width.
- DEPTH, 4, queue entries and the maximum number of outstanding requests; must be a power of two and ≥ 2.
- RESET_PC, 32'h0100_0000, PC after reset; must match PC_START.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- redirect_i  in  1  taken branch/jump from execute; flush and refetch.
- redirect_pc_i  in  AWIDTH  redirect target; bits [1:0] ignored (forced 0).
- req_valid_o  out  1  imem request valid.
- req_addr_o  out  AWIDTH  imem request address (word aligned).
- req_ready_i  in  1  imem accepts request.
- rsp_valid_i  in  1  imem response valid; in order, one per accepted request, latency ≥ 1, no backpressure.
- rsp_data_i  in  DWIDTH  returned instruction.
- inst_valid_o  out  1  queue head valid.
- inst_o  out  DWIDTH  head instruction.
- inst_pc_o  out  AWIDTH  head PC.
- inst_ready_i  in  1  decode consumes head (low = stall).
- count_o  out  $clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc and rsp_pc load RESET_PC.
  - count, inflight and drop_cnt clear to 0.
  - During rst, req_valid_o=0, inst_valid_o=0 and count_o=0.
  - Reset mid-operation discards all queue contents. The imem must be reset in the same cycle; responses to pre-reset requests are illegal.
- Request issue:
  - req_valid_o = !rst && !redirect_i && (count + inflight < DEPTH).
  - req_addr_o = fetch_pc.
  - req_fire = req_valid_o && req_ready_i. On req_fire, fetch_pc += 4, wrapping modulo 2^AWIDTH.
  - req_valid_o may rise only by this rule; once asserted, req_addr_o holds until the request fires or a redirect occurs.
- inflight counter: next = inflight + req_fire - rsp_valid_i. Range 0..DEPTH.
- Response acceptance:
  - A response is kept when rsp_valid_i && drop_cnt==0 && !redirect_i. A kept response writes {rsp_pc, rsp_data_i} into the queue tail and rsp_pc += 4.
  - If drop_cnt>0 the response is discarded and drop_cnt decrements.
  - The credit rule guarantees the queue never overflows on a kept response.
- Latency: request fires in cycle N, response arrives in N+L, inst_valid_o asserts in N+L+1. There is no response-to-output bypass.
- Dequeue:
  - inst_valid_o = (count != 0).
  - Pop when inst_valid_o && inst_ready_i && !redirect_i.
  - Simultaneous keep and pop leaves count unchanged.
- Redirect, in the cycle redirect_i=1:
  - No request is issued and no pop occurs.
  - The queue flushes, so count=0 next cycle.
  - fetch_pc and rsp_pc load {redirect_pc_i[AWIDTH-1:2], 2'b00}.
  - drop_cnt loads inflight - rsp_valid_i; a response arriving in the redirect cycle is itself dropped.
  - Back-to-back redirects: the latest wins, and drop_cnt is recomputed each time.
- Boundaries:
  - Full (count==DEPTH): no issue; outputs hold while inst_ready_i=0.
  - Empty: inst_valid_o=0, and inst_o/inst_pc_o are don't-care.
  - Queue pointers wrap modulo DEPTH.
- Assertions:
  - rsp_valid_i with inflight==0 is a protocol error.
  - count+inflight never exceeds DEPTH.
  - drop_cnt ≤ inflight.

Decomposition:
- PC_START and the instruction-width constants stay in constants.svh.
- Add a fetch_pkg typedef fetch_entry_t = struct {pc, inst}.
- One sub-module: fetch_fifo, a synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, flush and count. Flush takes priority over push and pop.
- The top level holds the PC, inflight and drop_cnt logic.

Test Plan:
- Stream (L=1, req_ready_i=1, inst_ready_i=1) → req_addr_o = 0x01000000, 0x04, 0x08…; inst_pc_o follows the same sequence; first inst_valid_o 2 cycles after the first req_fire; no gaps in steady state.
- Backpressure (inst_ready_i=0 from start) → count_o reaches 4 and req_valid_o stays 0. Then inst_ready_i=1 → PCs 0x01000000..0x0100000C popped in order, fetch resumes at 0x01000010, nothing lost or duplicated.
- Redirect with 2 in flight (L=3) to 0x01000100 → both stale responses dropped, count_o=0, next request addr 0x01000100, first inst_pc_o=0x01000100.
- Redirect coinciding with rsp_valid_i and inst_ready_i, count_o=2 → response dropped, no pop, count_o=0 next cycle, inst_valid_o=0.
- Misaligned redirect 0x01000102 → req_addr_o=0x01000100. Then redirect on two consecutive cycles (0x200, then 0x300) → only 0x01000300 is fetched.
- rst mid-stream with count_o=3 and inflight=1 (imem reset together) → next cycle count_o=0, inst_valid_o=0; after release req_addr_o=0x01000000.
